// File: rtl/hazard_fwd_unit.sv
// Forwarding select precompute and load-use hazard detection for the 5-stage RV32 pipeline.
// Shadows EX/MEM/WB destination info and registers EX operand selects one cycle ahead.
module hazard_fwd_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic              hold,
    output logic [1:0]        M1Sel,
    output logic [1:0]        M2Sel,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              idex_bubble,
    output logic [CNT_W-1:0]  lu_stall_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wen;
        logic              load;
    } stage_t;

    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_RF  = 2'b00;

    stage_t           ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [1:0]       m1sel_q, m1sel_d, m2sel_q, m2sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ex_live, mem_live, lu;

    // The producer now in EX will sit in MEM when the consumer reaches EX, hence 10.
    function automatic logic [1:0] fwd_sel(
        input logic              used,
        input logic [REG_AW-1:0] rs,
        input stage_t            ex,
        input logic              ex_ok,
        input stage_t            mem,
        input logic              mem_ok
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (used && ex_ok && !ex.load && rs == ex.rd)
            sel = SEL_MEM;
        else if (used && mem_ok && rs == mem.rd)
            sel = SEL_WB;
        return sel;
    endfunction

    always_comb begin
        ex_live  = ex_q.valid & ex_q.wen & (ex_q.rd != '0);
        mem_live = mem_q.valid & mem_q.wen & (mem_q.rd != '0);
        lu = id_valid & ex_live & ex_q.load &
             ((id_rs1_used & (id_rs1 == ex_q.rd)) | (id_rs2_used & (id_rs2 == ex_q.rd)));
    end

    assign pc_stall     = lu & ~flush & ~hold;
    assign ifid_stall   = lu & ~flush & ~hold;
    assign idex_bubble  = (lu | flush) & ~hold;
    assign M1Sel        = m1sel_q;
    assign M2Sel        = m2sel_q;
    assign lu_stall_cnt = cnt_q;

    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        m1sel_d = m1sel_q;
        m2sel_d = m2sel_q;
        cnt_d   = cnt_q;
        if (!hold) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (!lu && !flush) begin
                ex_d.valid = id_valid;
                ex_d.rd    = id_rd;
                ex_d.wen   = id_reg_write;
                ex_d.load  = id_mem_read;
                m1sel_d = id_valid ? fwd_sel(id_rs1_used, id_rs1, ex_q, ex_live, mem_q, mem_live) : SEL_RF;
                m2sel_d = id_valid ? fwd_sel(id_rs2_used, id_rs2, ex_q, ex_live, mem_q, mem_live) : SEL_RF;
            end else begin
                ex_d    = '0;
                m1sel_d = SEL_RF;
                m2sel_d = SEL_RF;
            end
            if (lu && !flush && cnt_q != '1)
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            m1sel_q <= SEL_RF;
            m2sel_q <= SEL_RF;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            m1sel_q <= m1sel_d;
            m2sel_q <= m2sel_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: forwarding selects, load-use stalls, flush/hold, saturation, reset.
module tb_hazard_fwd_unit;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              flush, hold;
    logic [1:0]        M1Sel, M2Sel;
    logic              pc_stall, ifid_stall, idex_bubble;
    logic [CNT_W-1:0]  lu_stall_cnt;

    int tests = 0;
    int fails = 0;

    hazard_fwd_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush), .hold(hold),
        .M1Sel(M1Sel), .M2Sel(M2Sel), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .idex_bubble(idex_bubble), .lu_stall_cnt(lu_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input int rs1, input int rs2, input logic u1,
                          input logic u2, input int rd, input logic wen, input logic ld);
        id_valid = v; id_rs1 = REG_AW'(rs1); id_rs2 = REG_AW'(rs2);
        id_rs1_used = u1; id_rs2_used = u2; id_rd = REG_AW'(rd);
        id_reg_write = wen; id_mem_read = ld;
        #1;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; hold = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step();
        rst = 0;
        tests++;
        if ({M1Sel, M2Sel, pc_stall, ifid_stall, idex_bubble} !== 7'b0 || lu_stall_cnt !== '0) begin
            fails++;
            $display("FAIL reset sel=%b/%b stall=%b%b%b cnt=%0d exp all 0",
                     M1Sel, M2Sel, pc_stall, ifid_stall, idex_bubble, lu_stall_cnt);
        end
    endtask

    task automatic test_ex_fwd();
        drain();
        set_id(1, 1, 0, 1, 0, 5, 1, 0); step();        // ADDI x5,x1
        set_id(1, 5, 1, 1, 1, 6, 1, 0);                // ADD x6,x5,x1
        tests++;
        if (pc_stall !== 1'b0 || idex_bubble !== 1'b0) begin
            fails++; $display("FAIL exfwd_nostall got stall=%b bubble=%b exp 0 0", pc_stall, idex_bubble);
        end
        step();
        tests++;
        if (M1Sel !== 2'b10 || M2Sel !== 2'b00) begin
            fails++; $display("FAIL exfwd_sel got %b/%b exp 10/00", M1Sel, M2Sel);
        end
    endtask

    task automatic test_mem_fwd();
        drain();
        set_id(1, 1, 0, 1, 0, 5, 1, 0); step();        // ADDI x5
        set_id(0, 0, 0, 0, 0, 0, 0, 0); step();        // NOP
        set_id(1, 2, 5, 1, 1, 7, 1, 0); step();        // SUB x7,x2,x5
        tests++;
        if (M1Sel !== 2'b00 || M2Sel !== 2'b01) begin
            fails++; $display("FAIL memfwd_sel got %b/%b exp 00/01", M1Sel, M2Sel);
        end
    endtask

    task automatic test_load_use();
        drain();
        set_id(1, 1, 0, 1, 0, 8, 1, 1); step();        // LW x8
        set_id(1, 8, 8, 1, 1, 9, 1, 0);                // ADD x9,x8,x8
        tests++;
        if ({pc_stall, ifid_stall, idex_bubble} !== 3'b111) begin
            fails++; $display("FAIL lu_stall got %b exp 111", {pc_stall, ifid_stall, idex_bubble});
        end
        step();
        tests++;
        if (pc_stall !== 1'b0 || M1Sel !== 2'b00 || M2Sel !== 2'b00) begin
            fails++; $display("FAIL lu_bubble got stall=%b sel=%b/%b exp 0 00/00", pc_stall, M1Sel, M2Sel);
        end
        step();
        tests++;
        if (M1Sel !== 2'b01 || M2Sel !== 2'b01 || lu_stall_cnt !== 8'd1) begin
            fails++; $display("FAIL lu_after got sel=%b/%b cnt=%0d exp 01/01 1", M1Sel, M2Sel, lu_stall_cnt);
        end
    endtask

    task automatic test_x0_and_priority();
        drain();
        set_id(1, 1, 0, 1, 0, 0, 1, 0); step();        // ADDI x0
        set_id(1, 0, 0, 1, 1, 3, 1, 0); step();        // ADD x3,x0,x0
        tests++;
        if (M1Sel !== 2'b00 || M2Sel !== 2'b00) begin
            fails++; $display("FAIL x0_sel got %b/%b exp 00/00", M1Sel, M2Sel);
        end
        drain();
        set_id(1, 1, 0, 1, 0, 4, 1, 0); step();        // ADDI x4
        set_id(1, 1, 0, 1, 0, 4, 1, 0); step();        // ADDI x4
        set_id(1, 4, 4, 1, 1, 5, 1, 0); step();        // ADD x5,x4,x4
        tests++;
        if (M1Sel !== 2'b10 || M2Sel !== 2'b10) begin
            fails++; $display("FAIL memwins_sel got %b/%b exp 10/10", M1Sel, M2Sel);
        end
        drain();
        set_id(1, 1, 0, 1, 0, 4, 1, 0); step();        // ADDI x4
        set_id(1, 4, 4, 1, 0, 5, 1, 0); step();        // rs2 matches but unused
        tests++;
        if (M1Sel !== 2'b10 || M2Sel !== 2'b00) begin
            fails++; $display("FAIL unused_sel got %b/%b exp 10/00", M1Sel, M2Sel);
        end
    endtask

    task automatic test_flush();
        drain();
        set_id(1, 1, 0, 1, 0, 8, 1, 1); step();        // LW x8
        set_id(1, 8, 0, 1, 0, 9, 1, 0);
        flush = 1; #1;
        tests++;
        if (pc_stall !== 1'b0 || ifid_stall !== 1'b0 || idex_bubble !== 1'b1) begin
            fails++; $display("FAIL flush_out got %b%b%b exp 001", pc_stall, ifid_stall, idex_bubble);
        end
        step();
        flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tests++;
        if (M1Sel !== 2'b00 || lu_stall_cnt !== 8'd1) begin
            fails++; $display("FAIL flush_after got sel=%b cnt=%0d exp 00 1", M1Sel, lu_stall_cnt);
        end
    endtask

    task automatic test_hold();
        drain();
        set_id(1, 1, 0, 1, 0, 4, 1, 0); step();        // ADDI x4
        set_id(1, 4, 0, 1, 0, 8, 1, 1); step();        // LW x8,(x4)
        set_id(1, 8, 8, 1, 1, 9, 1, 0);                // ADD x9,x8,x8
        hold = 1; #1;
        tests++;
        if ({pc_stall, ifid_stall, idex_bubble} !== 3'b000) begin
            fails++; $display("FAIL hold_out got %b exp 000", {pc_stall, ifid_stall, idex_bubble});
        end
        repeat (3) step();
        tests++;
        if (M1Sel !== 2'b10 || M2Sel !== 2'b00 || lu_stall_cnt !== 8'd1) begin
            fails++; $display("FAIL hold_frozen got sel=%b/%b cnt=%0d exp 10/00 1", M1Sel, M2Sel, lu_stall_cnt);
        end
        hold = 0; #1;
        tests++;
        if ({pc_stall, ifid_stall, idex_bubble} !== 3'b111) begin
            fails++; $display("FAIL hold_resume got %b exp 111", {pc_stall, ifid_stall, idex_bubble});
        end
        step();
        tests++;
        if (lu_stall_cnt !== 8'd2 || M1Sel !== 2'b00) begin
            fails++; $display("FAIL hold_stall got cnt=%0d sel=%b exp 2 00", lu_stall_cnt, M1Sel);
        end
        step();
        tests++;
        if (M1Sel !== 2'b01 || M2Sel !== 2'b01) begin
            fails++; $display("FAIL hold_fwd got %b/%b exp 01/01", M1Sel, M2Sel);
        end
    endtask

    task automatic test_saturate_and_reset();
        drain();
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            set_id(1, 1, 0, 1, 0, 8, 1, 1); step();
            set_id(1, 8, 0, 1, 0, 9, 1, 0); step();
        end
        tests++;
        if (lu_stall_cnt !== 8'hFF) begin
            fails++; $display("FAIL sat_cnt got %0d exp 255", lu_stall_cnt);
        end
        set_id(1, 1, 0, 1, 0, 8, 1, 1); step();
        set_id(1, 8, 8, 1, 1, 9, 1, 0);
        tests++;
        if (pc_stall !== 1'b1) begin
            fails++; $display("FAIL rst_pre got stall=%b exp 1", pc_stall);
        end
        rst = 1; step();
        tests++;
        if ({M1Sel, M2Sel, pc_stall, ifid_stall, idex_bubble} !== 7'b0 || lu_stall_cnt !== '0) begin
            fails++; $display("FAIL rst_mid got sel=%b/%b stall=%b%b%b cnt=%0d exp all 0",
                              M1Sel, M2Sel, pc_stall, ifid_stall, idex_bubble, lu_stall_cnt);
        end
        rst = 0; step();
        tests++;
        if (pc_stall !== 1'b0 || lu_stall_cnt !== '0) begin
            fails++; $display("FAIL rst_residual got stall=%b cnt=%0d exp 0 0", pc_stall, lu_stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_ex_fwd();
        test_mem_fwd();
        test_load_use();
        test_x0_and_priority();
        test_flush();
        test_hold();
        test_saturate_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout exceeded 200000 time units");
        $fatal(1);
    end
endmodule
